enemy_bullet_ctl: RTL

//  Generates and moves up to three enemy bullets that fall from the enemy toward the player ship.

---
 rtl/enemy_bullet_ctl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/enemy_bullet_ctl.sv
// enemy_bullet_ctl: spawns and moves up to three enemy bullets falling from
// the enemy toward the player ship. Bullet positions feed the ship collision
// detector, so every bullet is guaranteed to sit on Y_SHIP for exactly one
// frame on its way down.
//
// Ports
//   pclk            pixel clock, all state on rising edge
//   rst             asynchronous reset, active-high
//   frame_tick      one-cycle pulse per frame; motion and firing happen only here
//   enemy_X/Y       enemy centre X / bottom Y
//   enemy_alive     enemy allowed to fire
//   is_ship_display 0 = ship destroyed: bullets cleared, firing inhibited
//   enBullet_X_n/Y_n registered bullet n position (parked at 0,0 when idle)
//   enBullet_act    bit n-1 = bullet n in flight

// One bullet slot: IDLE/FLY with motion, landing clamp and retirement.
module enemy_bullet_slot #(
  parameter int BULLET_SPEED = 8,
  parameter int Y_SHIP       = 680,
  parameter int Y_BOTTOM     = 767
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        tick,
  input  logic        clear,
  input  logic        load,
  input  logic [10:0] load_x,
  input  logic [10:0] load_y,
  output logic        fly,
  output logic [10:0] x,
  output logic [10:0] y
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FLY  = 1'b1;

  logic [0:0]  state;
  logic [11:0] s;

  // 12-bit sum so a step past 2047 can't wrap back into the playfield.
  assign s   = {1'b0, y} + 12'(BULLET_SPEED);
  assign fly = (state == FLY);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else if (clear) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else if (tick) begin
      if (state == IDLE) begin
        if (load) begin
          state <= FLY;
          x     <= load_x;
          y     <= load_y;
        end
      end else begin
        // Clamp onto the ship row so the detector's equality test sees it.
        if (({1'b0, y} < 12'(Y_SHIP)) && (s > 12'(Y_SHIP))) begin
          y <= 11'(Y_SHIP);
        end else if (s > 12'(Y_BOTTOM)) begin
          state <= IDLE;
          x     <= '0;
          y     <= '0;
        end else begin
          y <= s[10:0];
        end
      end
    end
  end
endmodule

module enemy_bullet_ctl #(
  parameter int         BULLET_SPEED = 8,
  parameter int         SPAWN_OFFSET = 16,
  parameter int         FIRE_PERIOD  = 60,
  parameter logic [3:0] JITTER_MASK  = 4'hF,
  parameter int         Y_SHIP       = 680,
  parameter int         Y_BOTTOM     = 767
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [10:0] enemy_X,
  input  logic [10:0] enemy_Y,
  input  logic        enemy_alive,
  input  logic        is_ship_display,
  output logic [10:0] enBullet_X_1,
  output logic [10:0] enBullet_Y_1,
  output logic [10:0] enBullet_X_2,
  output logic [10:0] enBullet_Y_2,
  output logic [10:0] enBullet_X_3,
  output logic [10:0] enBullet_Y_3,
  output logic [2:0]  enBullet_act
);
  localparam int NUM_SLOTS = 3;

  logic [7:0]                  cooldown;
  logic [7:0]                  lfsr;
  logic [7:0]                  reload;
  logic                        fire;
  logic                        can_load;
  logic [NUM_SLOTS-1:0]        fly;
  logic [NUM_SLOTS-1:0]        free;
  logic [NUM_SLOTS-1:0]        load;
  logic [NUM_SLOTS-1:0][10:0]  bx;
  logic [NUM_SLOTS-1:0][10:0]  by;
  logic [11:0]                 spawn_sum;
  logic [10:0]                 spawn_y;

  assign fire     = frame_tick && (cooldown == 8'd1);
  assign can_load = fire && enemy_alive && is_ship_display;
  // Free is taken from current state, so a slot retiring this tick is
  // still busy for this fire event.
  assign free     = ~fly;

  // Lowest-index idle slot wins.
  assign load[0] = can_load && free[0];
  assign load[1] = can_load && free[1] && !free[0];
  assign load[2] = can_load && free[2] && !free[1] && !free[0];

  assign spawn_sum = {1'b0, enemy_Y} + 12'(SPAWN_OFFSET);
  assign spawn_y   = (spawn_sum > 12'(Y_BOTTOM)) ? 11'(Y_BOTTOM) : spawn_sum[10:0];

  assign reload = 8'(FIRE_PERIOD) + {4'b0, lfsr[3:0] & JITTER_MASK};

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cooldown <= 8'(FIRE_PERIOD);
      lfsr     <= 8'hA5;
    end else if (!is_ship_display) begin
      cooldown <= 8'(FIRE_PERIOD);
    end else if (frame_tick) begin
      if (cooldown == 8'd1) begin
        cooldown <= reload;
        // x^8+x^6+x^5+x^4+1
        lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end else begin
        cooldown <= cooldown - 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    enemy_bullet_slot #(
      .BULLET_SPEED (BULLET_SPEED),
      .Y_SHIP       (Y_SHIP),
      .Y_BOTTOM     (Y_BOTTOM)
    ) u_slot (
      .pclk   (pclk),
      .rst    (rst),
      .tick   (frame_tick),
      .clear  (!is_ship_display),
      .load   (load[i]),
      .load_x (enemy_X),
      .load_y (spawn_y),
      .fly    (fly[i]),
      .x      (bx[i]),
      .y      (by[i])
    );
  end

  assign enBullet_X_1 = bx[0];
  assign enBullet_Y_1 = by[0];
  assign enBullet_X_2 = bx[1];
  assign enBullet_Y_2 = by[1];
  assign enBullet_X_3 = bx[2];
  assign enBullet_Y_3 = by[2];
  assign enBullet_act = fly;
endmodule
